// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C bus arbiter: FSM state, command bit layout and
// a one-hot to index helper.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_BUSY,
        ST_RELEASE
    } arb_state_e;

    localparam int CMD_W   = 5;
    localparam int START   = 4;
    localparam int STOP    = 3;
    localparam int READ    = 2;
    localparam int WRITE   = 1;
    localparam int ACK     = 0;
    localparam int MAX_REQ = 8;

    // Field order matches the START..ACK indices above (first member is the MSB).
    typedef struct packed {
        logic start;
        logic stop;
        logic read;
        logic write;
        logic ack;
    } i2c_cmd_t;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester and core-side signal bundle of the I2C bus arbiter; the arbiter
// uses the slave modport, requesters plus the I2C core form the master side.
interface i2c_bus_arbiter_if #(parameter int N_REQ = 2);

    logic [N_REQ-1:0]       req_i;
    logic [N_REQ-1:0]       gnt_o;
    logic [N_REQ-1:0]       cmd_valid_i;
    logic [N_REQ*5-1:0]     cmd_i;
    logic [N_REQ*8-1:0]     txd_i;
    logic [N_REQ-1:0]       cmd_done_o;
    logic [N_REQ-1:0]       cmd_err_o;
    logic [7:0]             rxd_o;
    logic                   rx_ack_o;
    logic                   core_start_o;
    logic                   core_stop_o;
    logic                   core_read_o;
    logic                   core_write_o;
    logic                   core_ack_o;
    logic [7:0]             core_din_o;
    logic                   core_cmd_ack_i;
    logic                   core_ack_i;
    logic [7:0]             core_dout_i;
    logic                   core_al_i;
    logic                   core_abort_o;

    modport slave (
        input  req_i, cmd_valid_i, cmd_i, txd_i,
               core_cmd_ack_i, core_ack_i, core_dout_i, core_al_i,
        output gnt_o, cmd_done_o, cmd_err_o, rxd_o, rx_ack_o,
               core_start_o, core_stop_o, core_read_o, core_write_o, core_ack_o,
               core_din_o, core_abort_o
    );

    modport master (
        output req_i, cmd_valid_i, cmd_i, txd_i,
               core_cmd_ack_i, core_ack_i, core_dout_i, core_al_i,
        input  gnt_o, cmd_done_o, cmd_err_o, rxd_o, rx_ack_o,
               core_start_o, core_stop_o, core_read_o, core_write_o, core_ack_o,
               core_din_o, core_abort_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first set request at or
// after rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of a shared byte-level I2C master core; an owner keeps the
// bus until its STOP command completes. Define I2C_ARB_TIMEOUT_EN for a BUSY timeout.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input logic              clk_i,
    input logic              arst_i,
    i2c_bus_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    i2c_cmd_t         core_cmd_q, core_cmd_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             rx_ack_q, rx_ack_d;

    logic [N_REQ-1:0]   pick;
    logic [MAX_REQ-1:0] pick_ext;
    logic [PTR_W-1:0]   pick_idx;
    i2c_cmd_t           own_cmd;
    logic [7:0]         own_txd;
    logic               timeout;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req    (bus.req_i),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick)
    );

    always_comb begin
        pick_ext            = '0;
        pick_ext[N_REQ-1:0] = pick;
        pick_idx            = PTR_W'(onehot_to_idx(pick_ext));
    end

    always_comb begin
        own_cmd = '0;
        own_txd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_cmd = bus.cmd_i[i*CMD_W +: CMD_W];
                own_txd = bus.txd_i[i*8 +: 8];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;

    // Counter restarts whenever the FSM is outside BUSY, so it is zero on entry.
    assign cnt_d            = (state_q == ST_BUSY) ? cnt_q + 1'b1 : '0;
    assign timeout          = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign abort_d          = timeout && !bus.core_al_i;
    assign bus.core_abort_o = abort_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end
`else
    assign timeout          = 1'b0;
    assign bus.core_abort_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        err_d      = '0;
        core_cmd_d = core_cmd_q;
        din_d      = din_q;
        rxd_d      = rxd_q;
        rx_ack_d   = rx_ack_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    gnt_d    = pick;
                    owner_d  = pick_idx;
                    rr_ptr_d = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (bus.core_al_i) begin
                    err_d[owner_q] = 1'b1;
                    core_cmd_d     = '0;
                    gnt_d          = '0;
                    state_d        = ST_RELEASE;
                end else if (!bus.req_i[owner_q]) begin
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (bus.cmd_valid_i[owner_q]) begin
                    core_cmd_d = own_cmd;
                    din_d      = own_txd;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Arbitration loss outranks a same-cycle command ack.
                if (bus.core_al_i || timeout) begin
                    err_d[owner_q] = 1'b1;
                    core_cmd_d     = '0;
                    gnt_d          = '0;
                    state_d        = ST_RELEASE;
                end else if (bus.core_cmd_ack_i) begin
                    core_cmd_d      = '0;
                    rxd_d           = bus.core_dout_i;
                    rx_ack_d        = bus.core_ack_i;
                    done_d[owner_q] = 1'b1;
                    if (core_cmd_q.stop) begin
                        gnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_OWNED;
                    end
                end
            end
            ST_RELEASE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            core_cmd_q <= '0;
            din_q      <= '0;
            rxd_q      <= '0;
            rx_ack_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            core_cmd_q <= core_cmd_d;
            din_q      <= din_d;
            rxd_q      <= rxd_d;
            rx_ack_q   <= rx_ack_d;
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.cmd_done_o   = done_q;
    assign bus.cmd_err_o    = err_q;
    assign bus.rxd_o        = rxd_q;
    assign bus.rx_ack_o     = rx_ack_q;
    assign bus.core_start_o = core_cmd_q.start;
    assign bus.core_stop_o  = core_cmd_q.stop;
    assign bus.core_read_o  = core_cmd_q.read;
    assign bus.core_write_o = core_cmd_q.write;
    assign bus.core_ack_o   = core_cmd_q.ack;
    assign bus.core_din_o   = din_q;

endmodule
